div_ctrl: RTL and testbench

- Multi-cycle iterative divider controller for the EX stage: sequences a one-bit-per-cycle restoring divide for DIV/DIVU.
- Exposes a start/ready handshake so EX raises stallreq while a divide is in flight.
- Produces a 64-bit {remainder, quotient} result that EX writes to HI/LO, using the same whilo path as MULT/MADD.

---
 rtl/div_ctrl.sv | 150 +++++++++++++++
 tb/tb_div_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// Iterative restoring divider for DIV/DIVU in the EX stage.
// Produces one quotient bit per cycle and returns {remainder, quotient} with a start/ready handshake.
module div_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  busy_o
);

    // state    | meaning
    // IDLE     | waiting for start_i; outputs cleared
    // DIV_ZERO | divisor was zero; one cycle before reporting a zero result
    // DIV_ON   | one restoring iteration per cycle, DATA_W iterations
    // DIV_END  | result valid; held until start_i drops

    localparam int              CNT_W     = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, DIV_ZERO, DIV_ON, DIV_END} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   quo_q, quo_d;
    logic [DATA_W-1:0]   dsor_q, dsor_d;
    logic                sign1_q, sign1_d;
    logic                sign2_q, sign2_d;
    logic                sgn_q, sgn_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;

    logic [DATA_W-1:0]   abs1, abs2;
    logic [DATA_W:0]     shifted;
    logic [DATA_W+1:0]   trial;
    logic [DATA_W-1:0]   rem_nx, quo_nx, rem_fin, quo_fin;

    // Datapath: the shifted remainder can reach DATA_W+1 bits, so the trial
    // subtraction carries an extra bit above that to expose the borrow.
    always_comb begin
        abs1    = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
        abs2    = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
        shifted = {rem_q, quo_q[DATA_W-1]};
        trial   = {1'b0, shifted} - {2'b00, dsor_q};
        rem_nx  = trial[DATA_W+1] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
        quo_nx  = {quo_q[DATA_W-2:0], ~trial[DATA_W+1]};
        quo_fin = (sgn_q && (sign1_q != sign2_q)) ? -quo_nx : quo_nx;
        rem_fin = (sgn_q && sign1_q) ? -rem_nx : rem_nx;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dsor_d   = dsor_q;
        sign1_d  = sign1_q;
        sign2_d  = sign2_q;
        sgn_d    = sgn_q;
        result_d = result_q;
        ready_d  = ready_q;
        case (state_q)
            IDLE: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = DIV_ZERO;
                    end else begin
                        state_d = DIV_ON;
                        cnt_d   = '0;
                        rem_d   = '0;
                        quo_d   = abs1;
                        dsor_d  = abs2;
                        sign1_d = opdata1_i[DATA_W-1];
                        sign2_d = opdata2_i[DATA_W-1];
                        sgn_d   = signed_div_i;
                    end
                end
            end
            DIV_ZERO: begin
                state_d  = DIV_END;
                result_d = '0;
                ready_d  = 1'b1;
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_d  = IDLE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_d  = DIV_END;
                        result_d = {rem_fin, quo_fin};
                        ready_d  = 1'b1;
                    end
                end
            end
            DIV_END: begin
                if (!start_i) begin
                    state_d  = IDLE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dsor_q   <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            sgn_q    <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dsor_q   <= dsor_d;
            sign1_q  <= sign1_d;
            sign2_q  <= sign2_d;
            sgn_q    <= sgn_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
    assign busy_o   = (state_q == DIV_ZERO) || (state_q == DIV_ON);

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: directed vector table, random operands against an
// arithmetic reference, and hand sequences for annul, reset and hold behaviour.
module tb_div_ctrl;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1, op2;
    logic        start, annul;
    logic [63:0] result;
    logic        ready, busy;

    int checks   = 0;
    int failures = 0;

    div_ctrl #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    typedef struct {
        string       name;
        bit          sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
        end
    endtask

    // Truncating division, remainder takes the dividend's sign; x/0 gives 0.
    function automatic logic [63:0] ref_div(input bit sg, input logic [31:0] a, input logic [31:0] b);
        longint na, nb, q, r;
        if (b == 32'h0) return 64'h0;
        if (sg) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'h0, a});
            nb = longint'({32'h0, b});
        end
        q = na / nb;
        r = na % nb;
        return {r[31:0], q[31:0]};
    endfunction

    // Called just after a falling edge. Starts a divide, swaps the operands to
    // a2/b2 after the start edge, checks timing, result, hold and clear.
    task automatic run_div(input string nm, input bit sg, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] a2, input logic [31:0] b2, input logic [63:0] exp);
        int lat, busy_n, lat_exp;
        bit ok;
        signed_div = sg; op1 = a; op2 = b; start = 1'b1; annul = 1'b0;
        lat = 0; busy_n = 0;
        lat_exp = (b == 32'h0) ? 2 : 33;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin op1 = a2; op2 = b2; end
            if (ready) lat = c;
            else if (busy) busy_n++;
        end
        chk({nm, " latency"}, 64'(lat), 64'(lat_exp));
        chk({nm, " busy_cycles"}, 64'(busy_n), 64'(lat_exp - 1));
        chk({nm, " result"}, result, exp);
        ok = 1'b1;
        for (int h = 0; h < 3; h++) begin
            annul = (h == 1);
            @(negedge clk);
            if (!ready || busy || result !== exp) ok = 1'b0;
        end
        annul = 1'b0;
        chk({nm, " hold"}, 64'(ok), 64'd1);
        start = 1'b0;
        @(negedge clk);
        chk({nm, " clear_result"}, result, 64'h0);
        chk({nm, " clear_flags"}, {62'h0, ready, busy}, 64'h0);
    endtask

    vec_t vt[$];

    initial begin
        bit          ok, sg;
        logic [31:0] a, b;

        vt.push_back('{"divu_100_7",       1'b0, 32'd100,      32'd7,          64'h00000002_0000000E});
        vt.push_back('{"div_m7_2",         1'b1, 32'hFFFFFFF9, 32'd2,          64'hFFFFFFFF_FFFFFFFD});
        vt.push_back('{"div_7_m2",         1'b1, 32'd7,        32'hFFFFFFFE,   64'h00000001_FFFFFFFD});
        vt.push_back('{"div_m7_m2",        1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE,   64'hFFFFFFFF_00000003});
        vt.push_back('{"div_min_m1",       1'b1, 32'h80000000, 32'hFFFFFFFF,   64'h00000000_80000000});
        vt.push_back('{"div_zero_signed",  1'b1, 32'h1234,     32'h0,          64'h0});
        vt.push_back('{"divu_zero",        1'b0, 32'h1234,     32'h0,          64'h0});
        vt.push_back('{"divu_ffff_10",     1'b0, 32'hFFFFFFFF, 32'h10,         64'h0000000F_0FFFFFFF});
        vt.push_back('{"divu_big_big",     1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE,   64'h00000001_00000001});
        vt.push_back('{"divu_8000_8000",   1'b0, 32'h80000000, 32'h80000000,   64'h00000000_00000001});

        rst = 1'b1; signed_div = 1'b0; op1 = '0; op2 = '0; start = 1'b0; annul = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset result", result, 64'h0);
        chk("reset flags", {62'h0, ready, busy}, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vt[i])
            run_div(vt[i].name, vt[i].sg, vt[i].a, vt[i].b, vt[i].a, vt[i].b, vt[i].exp);

        // Operands switched after the start edge must be ignored.
        run_div("operand_change", 1'b0, 32'd50, 32'd5, 32'd9, 32'd3, 64'h00000000_0000000A);

        // Annul during iteration 10, then an immediate new divide.
        signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        ok = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (!busy || ready) ok = 1'b0;
        end
        chk("annul pre_busy", 64'(ok), 64'd1);
        annul = 1'b1; start = 1'b0;
        @(negedge clk);
        annul = 1'b0;
        chk("annul flags", {62'h0, ready, busy}, 64'h0);
        chk("annul result", result, 64'h0);
        run_div("after_annul", 1'b0, 32'hFFFFFFFF, 32'h10, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF);

        // Reset at iteration 20.
        signed_div = 1'b1; op1 = 32'hFFFFFFF9; op2 = 32'd2; start = 1'b1;
        for (int c = 1; c <= 20; c++) @(negedge clk);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        chk("midrst result", result, 64'h0);
        chk("midrst flags", {62'h0, ready, busy}, 64'h0);
        rst = 1'b0;
        @(negedge clk);
        run_div("after_rst", 1'b0, 32'd100, 32'd7, 32'd100, 32'd7, 64'h00000002_0000000E);

        // start together with annul in IDLE must not launch a divide.
        start = 1'b1; annul = 1'b1; op1 = 32'd9; op2 = 32'd3;
        ok = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (busy || ready || result !== 64'h0) ok = 1'b0;
        end
        chk("start_annul idle", 64'(ok), 64'd1);
        start = 1'b0; annul = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 30; n++) begin
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'h0;
                1:       b = 32'($urandom_range(1, 20));
                2:       b = -32'($urandom_range(1, 20));
                3:       begin a = 32'h80000000; b = $urandom; end
                default: b = $urandom;
            endcase
            run_div($sformatf("rand%0d", n), sg, a, b, a, b, ref_div(sg, a, b));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
